// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// instruction-fetch (I) and load/store (D) requesters of the core.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise
// D has fixed priority over I.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          sel,
    output logic          busy
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [AW-1:0]   lat_addr, lat_addr_nxt;
    logic [DW-1:0]   lat_wdata, lat_wdata_nxt;
    logic            lat_we, lat_we_nxt;
    logic            sel_nxt;
    logic            i_ack_nxt, d_ack_nxt;
    logic [DW-1:0]   i_rdata_nxt, d_rdata_nxt;
    logic            mem_en_nxt, mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;
    logic            busy_nxt;
    logic            grant_d;

`ifdef ARB_RR_EN
    logic            last_d, last_d_nxt;

    // Round-robin: on a tie the requester not granted last wins
    assign grant_d = d_req & (~i_req | ~last_d);
`else
    // Fixed priority: D always beats I
    assign grant_d = d_req;
`endif

    // Next-state and next-output logic; all outputs are registered below
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        lat_we_nxt    = lat_we;
        sel_nxt       = sel;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        busy_nxt      = 1'b0;
`ifdef ARB_RR_EN
        last_d_nxt    = last_d;
`endif
        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    lat_addr_nxt  = grant_d ? d_addr : i_addr;
                    lat_wdata_nxt = grant_d ? d_wdata : '0;
                    lat_we_nxt    = grant_d & d_we;
                    sel_nxt       = grant_d;
                    cnt_nxt       = CW'(MEM_LAT - 1);
                    state_nxt     = BUSY;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = lat_we_nxt;
                    mem_addr_nxt  = lat_addr_nxt;
                    mem_wdata_nxt = lat_wdata_nxt;
                    busy_nxt      = 1'b1;
`ifdef ARB_RR_EN
                    last_d_nxt    = grant_d;
`endif
                end
            end
            BUSY: begin
                busy_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    i_ack_nxt = ~sel;
                    d_ack_nxt = sel;
                    if (!lat_we) begin
                        if (sel) d_rdata_nxt = mem_rdata;
                        else     i_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt       = cnt - CW'(1);
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = lat_we;
                    mem_addr_nxt  = lat_addr;
                    mem_wdata_nxt = lat_wdata;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            sel       <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_we    <= lat_we_nxt;
            sel       <= sel_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            busy      <= busy_nxt;
`ifdef ARB_RR_EN
            last_d    <= last_d_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (MEM_LAT=2 main instance,
// MEM_LAT=1 second instance for the single-cycle BUSY case).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_en, mem_we, sel, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        l1_i_req;
    logic [31:0] l1_i_addr;
    logic        l1_i_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_sel, l1_busy;
    logic [31:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory content as seen by the bench
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100)      return 32'hE3A0_1005;
        else if (a == 32'h0000_2000) return 32'h1234_5678;
        else                         return a ^ 32'h5A5A_0000;
    endfunction

    assign mem_rdata    = mem_f(mem_addr);
    assign l1_mem_rdata = mem_f(l1_mem_addr);

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sel(sel), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
        .sel(l1_sel), .busy(l1_busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic found;
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'h0;
        l1_i_req = 1'b0; l1_i_addr = 32'h0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({i_ack, d_ack, mem_en, mem_we, sel, busy, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got en=%b busy=%b sel=%b addr=%h irdata=%h exp all zero",
                         c, mem_en, busy, sel, mem_addr, i_rdata);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if (sel !== 1'b1 || mem_addr !== 32'h2000 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant got sel=%b addr=%h en=%b exp sel=1 addr=00002000 en=1",
                     sel, mem_addr, mem_en);
        end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (d_ack) begin found = 1'b1; d_req = 1'b0; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reset_d_ack got none exp d_ack within 10 cycles"); end
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (i_ack) begin found = 1'b1; i_req = 1'b0; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL reset_i_ack got none exp i_ack within 10 cycles"); end
        tick();
    endtask

    task automatic test_fetch;
        i_req = 1'b1; i_addr = 32'h100;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || sel !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL fetch_busy cycle=%0d got en=%b we=%b addr=%h sel=%b busy=%b exp 1 0 00000100 0 1",
                         c, mem_en, mem_we, mem_addr, sel, busy);
            end
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'hE3A01005 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack got i_ack=%b d_ack=%b i_rdata=%h en=%b exp 1 0 e3a01005 0",
                     i_ack, d_ack, i_rdata, mem_en);
        end
        i_req = 1'b0;
        tick();
        checks++;
        if (i_ack !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL fetch_idle got i_ack=%b busy=%b addr=%h exp 0 0 00000000", i_ack, busy, mem_addr);
        end
    endtask

    task automatic test_priority;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        tick(); tick();
        checks++;
        if (sel !== 1'b1 || mem_addr !== 32'h2000 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL prio_d_first got sel=%b addr=%h en=%b exp 1 00002000 1", sel, mem_addr, mem_en);
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL prio_d_ack got d_ack=%b i_ack=%b d_rdata=%h exp 1 0 12345678", d_ack, i_ack, d_rdata);
        end
        d_req = 1'b0;
        tick();
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap got en=%b busy=%b exp 0 0", mem_en, busy);
        end
        for (int c = 5; c <= 6; c++) begin
            tick();
            checks++;
            if (mem_addr !== 32'h100 || sel !== 1'b0 || mem_en !== 1'b1) begin
                failures++;
                $display("FAIL prio_i_busy cycle=%0d got addr=%h sel=%b en=%b exp 00000100 0 1", c, mem_addr, sel, mem_en);
            end
        end
        tick();
        checks++;
        if (i_ack !== 1'b1 || i_rdata !== 32'hE3A01005) begin
            failures++;
            $display("FAIL prio_i_ack got i_ack=%b i_rdata=%h exp 1 e3a01005", i_ack, i_rdata);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic       order [4];
        logic       exp_order [4];
        int         n;
`ifdef ARB_RR_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`endif
        for (int k = 0; k < 4; k++) order[k] = 1'b0;
        n = 0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (d_ack || i_ack) begin
                order[n] = d_ack;
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (n != 4) begin failures++; $display("FAIL b2b_count got %0d acks exp 4", n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (order[k] !== exp_order[k]) begin
                failures++;
                $display("FAIL b2b_order idx=%0d got d=%b exp d=%b", k, order[k], exp_order[k]);
            end
        end
        tick();
    endtask

    task automatic test_store;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            d_addr = 32'h4444; d_wdata = 32'h0; d_we = 1'b0;
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 || mem_wdata !== 32'hDEADBEEF || sel !== 1'b1) begin
                failures++;
                $display("FAIL store_busy cycle=%0d got en=%b we=%b addr=%h wdata=%h sel=%b exp 1 1 00003000 deadbeef 1",
                         c, mem_en, mem_we, mem_addr, mem_wdata, sel);
            end
        end
        tick();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h12345678 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL store_ack got d_ack=%b d_rdata=%h we=%b exp 1 12345678 0", d_ack, d_rdata, mem_we);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        logic seen;
        i_req = 1'b1; i_addr = 32'h100;
        tick();
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL abort_pre got en=%b addr=%h exp 1 00000100", mem_en, mem_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; i_req = 1'b0;
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || i_ack !== 1'b0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_state got en=%b busy=%b i_ack=%b i_rdata=%h d_rdata=%h exp 0 0 0 0 0",
                     mem_en, busy, i_ack, i_rdata, d_rdata);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (i_ack || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack got ack_or_busy=1 exp 0"); end
    endtask

    task automatic test_lat1;
        l1_i_req = 1'b1; l1_i_addr = 32'h100;
        tick();
        checks++;
        if (l1_mem_en !== 1'b1 || l1_mem_addr !== 32'h100 || l1_busy !== 1'b1) begin
            failures++;
            $display("FAIL lat1_busy got en=%b addr=%h busy=%b exp 1 00000100 1", l1_mem_en, l1_mem_addr, l1_busy);
        end
        tick();
        checks++;
        if (l1_i_ack !== 1'b1 || l1_mem_en !== 1'b0 || l1_i_rdata !== 32'hE3A01005) begin
            failures++;
            $display("FAIL lat1_ack got i_ack=%b en=%b i_rdata=%h exp 1 0 e3a01005", l1_i_ack, l1_mem_en, l1_i_rdata);
        end
        l1_i_req = 1'b0;
        tick();
        checks++;
        if (l1_i_ack !== 1'b0 || l1_busy !== 1'b0) begin
            failures++;
            $display("FAIL lat1_idle got i_ack=%b busy=%b exp 0 0", l1_i_ack, l1_busy);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_store();
        test_reset_mid();
        test_lat1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between the instruction-fetch requester (I) and the load/store requester (D) of the 32-bit ARM core.
- Latches the winning request and sequences a fixed-latency memory access.
- Drives the select line of the address/data steering mux.
- Returns read data with a one-cycle acknowledge to the granted requester.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, memory access latency in cycles (>=1); mem_rdata is valid in the last BUSY cycle

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request; held until i_ack
i_addr  input  AW  fetch address
i_ack  output  1  one-cycle fetch completion pulse
i_rdata  output  DW  fetched word, registered
d_req  input  1  data request; held until d_ack
d_we  input  1  1 = store, 0 = load
d_addr  input  AW  data address
d_wdata  input  DW  store data
d_ack  output  1  one-cycle data completion pulse
d_rdata  output  DW  load data, registered
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data
sel  output  1  steering-mux select: 0 = I, 1 = D
busy  output  1  high in BUSY and DONE

Behaviour:
- Interface: single clock domain, clk; synchronous active-high reset. Reset takes effect at the clk edge only.
- Reset values: state IDLE; sel=0; i_ack=d_ack=0; i_rdata=d_rdata=0; mem_en=mem_we=0; mem_addr=mem_wdata=0; busy=0; latched address/data/we cleared.
- States: IDLE, BUSY, DONE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Any request: grant, latch winner's addr/wdata/we, set sel, load counter with MEM_LAT-1, go to BUSY.
- Arbitration (default): D has fixed priority over I when both are asserted in the same IDLE cycle.
- BUSY:
  - mem_en=1; mem_addr/mem_wdata from latched values; mem_we=latched we (always 0 for I).
  - Counter decrements each cycle.
  - At count 0: capture mem_rdata into the granted requester's rdata register (loads/fetches only), go to DONE.
- DONE:
  - Assert the granted requester's ack for exactly one cycle.
  - mem_en=0; go to IDLE.
  - Requests are not sampled in DONE, so a request dropped after ack is never re-granted.
- Outside BUSY: mem_en, mem_we, mem_addr and mem_wdata are all 0.
- sel: registered; holds last grant through IDLE; changes only on grant.
- Latency: request seen in IDLE cycle t -> BUSY t+1..t+MEM_LAT -> ack at t+MEM_LAT+1.
- Back-to-back: next grant no earlier than t+MEM_LAT+2, giving one transfer per MEM_LAT+2 cycles.
- Stores: d_rdata is unchanged; d_ack still pulses.
- Inputs change after grant: changes to addr/wdata/we are ignored until the next grant.
- Reset mid-operation (BUSY or DONE): access aborted, no ack issued, rdata registers cleared, IDLE next cycle.
- MEM_LAT=1: BUSY lasts exactly one cycle.

Optional Feature:
ARB_RR_EN
- Defined: round-robin arbitration.
  - A last-grant pointer resets to I and is updated on every grant.
  - When both request in IDLE, the requester not granted last wins; D therefore wins the first contest after reset.
  - A single requester always wins regardless of the pointer.
- Undefined: fixed D-over-I priority, no pointer register. I can starve while D requests continuously.

Test Plan:
1. reset held 2 cycles with i_req=d_req=1 -> all outputs 0 during reset. Release -> first grant sel=1 in the cycle after release.
2. MEM_LAT=2, i_req at cycle 0, i_addr=0x100, mem_rdata=0xE3A01005 -> mem_en=1, mem_addr=0x100 in cycles 1-2; i_ack=1 in cycle 3; i_rdata=0xE3A01005; sel=0.
3. MEM_LAT=2, i_req and d_req (load, 0x2000) both at cycle 0, macro undefined -> d_ack in cycle 3; I granted in cycle 4; mem_addr=0x100 in cycles 5-6; i_ack in cycle 7.
4. ARB_RR_EN defined, both requesters re-request immediately after each ack for 4 transfers -> ack order D, I, D, I.
5. Store d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF, MEM_LAT=2 -> mem_we=1 with those values in cycles 1-2; d_ack in cycle 3; d_rdata unchanged.
6. reset asserted in cycle 1 of a fetch (BUSY) -> mem_en=0 and IDLE in cycle 2; i_ack never asserts; i_rdata=0.
